// File: rtl/ro_bus_capture_if.sv
// Readout-bus capture port bundle: shared bus lines in, tagged event words out.
// ev_ts is present only when RO_CAPTURE_TIMESTAMP_EN is defined.
interface ro_bus_capture_if #(
    parameter int CNT_W      = 19,
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             bus_eve;
    logic             bus_pol_eve;

    // Handshake: the head word transfers at a posedge where ev_valid & ev_ready are both 1.
    // ev_valid never depends on ev_ready; the head word holds steady until it is accepted.
    logic             ev_valid;
    logic             ev_ready;
    logic [4:0]       ev_core;
    logic             ev_pol;
`ifdef RO_CAPTURE_TIMESTAMP_EN
    logic [CNT_W-1:0] ev_ts;
`endif
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

`ifdef RO_CAPTURE_TIMESTAMP_EN
    modport master (
        output bus_eve, bus_pol_eve, ev_ready,
        input  ev_valid, ev_core, ev_pol, ev_ts, fifo_level, overflow
    );
    modport slave (
        input  bus_eve, bus_pol_eve, ev_ready,
        output ev_valid, ev_core, ev_pol, ev_ts, fifo_level, overflow
    );
`else
    modport master (
        output bus_eve, bus_pol_eve, ev_ready,
        input  ev_valid, ev_core, ev_pol, fifo_level, overflow
    );
    modport slave (
        input  bus_eve, bus_pol_eve, ev_ready,
        output ev_valid, ev_core, ev_pol, fifo_level, overflow
    );
`endif
endinterface

// File: rtl/ro_bus_capture.sv
// Off-core receiver for the time-multiplexed readout bus: replicates the gray-counter slot
// schedule, tags sampled events with their owning core and buffers them in a show-ahead FIFO.
// Define RO_CAPTURE_TIMESTAMP_EN to also store the slot count per word and expose ev_ts.
module ro_bus_capture #(
    parameter int CNT_W      = 19,
    parameter int N_CORES    = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk_master,
    input  logic            rstb,
    ro_bus_capture_if.slave rb
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         LVL_W     = AW + 1;
    localparam logic [4:0] N_CORES_L = 5'(N_CORES);
`ifdef RO_CAPTURE_TIMESTAMP_EN
    localparam int         WORD_W    = 6 + CNT_W;
`else
    localparam int         WORD_W    = 6;
`endif

    // Owner of slot k is the gray bit that flips when loading k: ctz(k)+1, or the MSB on wrap.
    function automatic logic [4:0] slot_owner(input logic [CNT_W-1:0] k);
        logic [4:0] o;
        o = 5'(CNT_W);
        for (int i = CNT_W - 1; i >= 0; i--) begin
            if (k[i]) o = 5'(i + 1);
        end
        return o;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       slot_core_q, slot_core_d;
    logic             slot_ok_q, slot_ok_d;

    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        slot_core_d = slot_owner(cnt_d);
        slot_ok_d   = (slot_core_d <= N_CORES_L);
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt_q       <= '0;
            slot_core_q <= '0;
            slot_ok_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slot_core_q <= slot_core_d;
            slot_ok_q   <= slot_ok_d;
        end
    end

    // Negedge sampling lands in the middle of the high-phase tristate-enable window.
    logic       stg_eve_q;
    logic       stg_pol_q;
    logic       stg_ok_q;
    logic [4:0] stg_core_q;
`ifdef RO_CAPTURE_TIMESTAMP_EN
    logic [CNT_W-1:0] stg_cnt_q;
`endif

    always_ff @(negedge clk_master or negedge rstb) begin
        if (!rstb) begin
            stg_eve_q  <= 1'b0;
            stg_pol_q  <= 1'b0;
            stg_ok_q   <= 1'b0;
            stg_core_q <= '0;
`ifdef RO_CAPTURE_TIMESTAMP_EN
            stg_cnt_q  <= '0;
`endif
        end else begin
            stg_eve_q  <= rb.bus_eve;
            stg_pol_q  <= rb.bus_pol_eve;
            stg_ok_q   <= slot_ok_q;
            stg_core_q <= slot_core_q;
`ifdef RO_CAPTURE_TIMESTAMP_EN
            stg_cnt_q  <= cnt_q;
`endif
        end
    end

    logic              push;
    logic [WORD_W-1:0] push_word;

    assign push = stg_eve_q & stg_ok_q;
`ifdef RO_CAPTURE_TIMESTAMP_EN
    assign push_word = {stg_core_q, stg_pol_q, stg_cnt_q};
`else
    assign push_word = {stg_core_q, stg_pol_q};
`endif

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] head_q, head_d;
    logic              full;
    logic              pop;
    logic              push_acc;

    always_comb begin
        full     = (count_q == LVL_W'(FIFO_DEPTH));
        pop      = (count_q != '0) & rb.ev_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_acc = push & (~full | pop);
        wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_acc & ~pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (pop & ~push_acc) begin
            count_d = count_q - LVL_W'(1);
        end
        ovf_d  = ovf_q | (push & full & ~pop);
        // Head register holds its last value once the FIFO drains.
        head_d = head_q;
        if (count_d != '0) begin
            if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_word;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_master) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    assign rb.ev_valid   = (count_q != '0);
    assign rb.fifo_level = count_q;
    assign rb.overflow   = ovf_q;
    assign rb.ev_core    = head_q[WORD_W-1 -: 5];
    assign rb.ev_pol     = head_q[WORD_W-6];
`ifdef RO_CAPTURE_TIMESTAMP_EN
    assign rb.ev_ts      = head_q[CNT_W-1:0];
`endif

endmodule

// File: tb/tb_ro_bus_capture.sv
// Bench for ro_bus_capture: three parameterisations share one bus stimulus; each has a
// posedge reference queue model whose head is compared against the DUT at every negedge.
module tb_ro_bus_capture;
    localparam int W = 38;

    logic clk_master = 1'b0;
    logic rstb       = 1'b1;
    logic drv_eve    = 1'b0;
    logic drv_pol    = 1'b0;
    logic drv_ready  = 1'b1;
    logic chk_en     = 1'b0;
    int   checks     = 0;
    int   errors     = 0;

    always #5 clk_master = ~clk_master;

    ro_bus_capture_if #(.CNT_W(19), .FIFO_DEPTH(8)) ifa ();
    ro_bus_capture_if #(.CNT_W(5),  .FIFO_DEPTH(4)) ifb ();
    ro_bus_capture_if #(.CNT_W(4),  .FIFO_DEPTH(4)) ifc ();

    assign ifa.bus_eve     = drv_eve;
    assign ifa.bus_pol_eve = drv_pol;
    assign ifa.ev_ready    = drv_ready;
    assign ifb.bus_eve     = drv_eve;
    assign ifb.bus_pol_eve = drv_pol;
    assign ifb.ev_ready    = 1'b1;
    assign ifc.bus_eve     = drv_eve;
    assign ifc.bus_pol_eve = drv_pol;
    assign ifc.ev_ready    = 1'b1;

    ro_bus_capture #(.CNT_W(19), .N_CORES(19), .FIFO_DEPTH(8)) dut_a (
        .clk_master(clk_master), .rstb(rstb), .rb(ifa));
    ro_bus_capture #(.CNT_W(5), .N_CORES(4), .FIFO_DEPTH(4)) dut_b (
        .clk_master(clk_master), .rstb(rstb), .rb(ifb));
    ro_bus_capture #(.CNT_W(4), .N_CORES(4), .FIFO_DEPTH(4)) dut_c (
        .clk_master(clk_master), .rstb(rstb), .rb(ifc));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int tb_owner(input int k, input int cntw);
        if (k == 0) return cntw;
        for (int i = 0; i < cntw; i++) begin
            if (k[i]) return i + 1;
        end
        return cntw;
    endfunction

    function automatic logic [W-1:0] mk_word(input int k, input int cntw, input logic pol);
        return {5'(tb_owner(k, cntw)), pol, 32'(k)};
    endfunction

    // Reference models: word = {core[4:0], pol, ts[31:0]}; the queue is the expected FIFO.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] qc[$];
    int           ka = 0, kb = 0, kc = 0;
    logic         oka = 1'b0, okb = 1'b0, okc = 1'b0;
    logic         ovfa = 1'b0, ovfb = 1'b0, ovfc = 1'b0;
    logic [W-1:0] lasta = '0, lastb = '0, lastc = '0;
    logic         a_push, a_pop, a_full, b_push, b_pop, b_full, c_push, c_pop, c_full;

    always @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            qa.delete(); ka = 0; oka = 1'b0; ovfa = 1'b0; lasta = '0;
        end else begin
            a_push = drv_eve && oka && (tb_owner(ka, 19) <= 19);
            a_full = (qa.size() == 8);
            a_pop  = (qa.size() > 0) && drv_ready;
            if (a_pop) void'(qa.pop_front());
            if (a_push && a_full && !a_pop) ovfa = 1'b1;
            else if (a_push) qa.push_back(mk_word(ka, 19, drv_pol));
            if (qa.size() > 0) lasta = qa[0];
            ka  = (ka + 1) % (1 << 19);
            oka = 1'b1;
        end
    end

    always @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            qb.delete(); kb = 0; okb = 1'b0; ovfb = 1'b0; lastb = '0;
        end else begin
            b_push = drv_eve && okb && (tb_owner(kb, 5) <= 4);
            b_full = (qb.size() == 4);
            b_pop  = (qb.size() > 0);
            if (b_pop) void'(qb.pop_front());
            if (b_push && b_full && !b_pop) ovfb = 1'b1;
            else if (b_push) qb.push_back(mk_word(kb, 5, drv_pol));
            if (qb.size() > 0) lastb = qb[0];
            kb  = (kb + 1) % (1 << 5);
            okb = 1'b1;
        end
    end

    always @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            qc.delete(); kc = 0; okc = 1'b0; ovfc = 1'b0; lastc = '0;
        end else begin
            c_push = drv_eve && okc && (tb_owner(kc, 4) <= 4);
            c_full = (qc.size() == 4);
            c_pop  = (qc.size() > 0);
            if (c_pop) void'(qc.pop_front());
            if (c_push && c_full && !c_pop) ovfc = 1'b1;
            else if (c_push) qc.push_back(mk_word(kc, 4, drv_pol));
            if (qc.size() > 0) lastc = qc[0];
            kc  = (kc + 1) % (1 << 4);
            okc = 1'b1;
        end
    end

    always @(negedge clk_master) begin
        if (chk_en) begin
            check("a_valid", 64'(ifa.ev_valid),   64'(qa.size() > 0));
            check("a_level", 64'(ifa.fifo_level), 64'(qa.size()));
            check("a_ovf",   64'(ifa.overflow),   64'(ovfa));
            check("a_core",  64'(ifa.ev_core),    64'(lasta[37:33]));
            check("a_pol",   64'(ifa.ev_pol),     64'(lasta[32]));
            check("b_valid", 64'(ifb.ev_valid),   64'(qb.size() > 0));
            check("b_level", 64'(ifb.fifo_level), 64'(qb.size()));
            check("b_ovf",   64'(ifb.overflow),   64'(ovfb));
            check("b_core",  64'(ifb.ev_core),    64'(lastb[37:33]));
            check("b_pol",   64'(ifb.ev_pol),     64'(lastb[32]));
            check("c_valid", 64'(ifc.ev_valid),   64'(qc.size() > 0));
            check("c_level", 64'(ifc.fifo_level), 64'(qc.size()));
            check("c_ovf",   64'(ifc.overflow),   64'(ovfc));
            check("c_core",  64'(ifc.ev_core),    64'(lastc[37:33]));
            check("c_pol",   64'(ifc.ev_pol),     64'(lastc[32]));
`ifdef RO_CAPTURE_TIMESTAMP_EN
            check("a_ts",    64'(ifa.ev_ts),      64'(lasta[18:0]));
            check("b_ts",    64'(ifb.ev_ts),      64'(lastb[4:0]));
            check("c_ts",    64'(ifc.ev_ts),      64'(lastc[3:0]));
`endif
        end
    end

    task automatic cyc(input logic eve, input logic pol);
        @(posedge clk_master);
        #1;
        drv_eve = eve;
        drv_pol = pol;
    endtask

    task automatic do_reset();
        @(posedge clk_master);
        #1;
        rstb    = 1'b0;
        drv_eve = 1'b0;
        drv_pol = 1'b0;
        #1;
        check("rst_valid", 64'(ifa.ev_valid),   64'(0));
        check("rst_level", 64'(ifa.fifo_level), 64'(0));
        check("rst_ovf",   64'(ifa.overflow),   64'(0));
        check("rst_core",  64'(ifa.ev_core),    64'(0));
        check("rst_pol",   64'(ifa.ev_pol),     64'(0));
        @(negedge clk_master);
        #2 rstb = 1'b1;
    endtask

    initial begin
        #1 rstb = 1'b0;
        #1;
        check("por_valid", 64'(ifa.ev_valid),   64'(0));
        check("por_level", 64'(ifa.fifo_level), 64'(0));
        check("por_ovf",   64'(ifa.overflow),   64'(0));
        repeat (2) @(posedge clk_master);
        @(negedge clk_master);
        #2 rstb = 1'b1;
        chk_en = 1'b1;

        // Single event in the first slot: one word, visible for one cycle.
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("t1_valid", 64'(ifa.ev_valid), 64'(1));
        check("t1_core",  64'(ifa.ev_core),  64'(1));
        check("t1_pol",   64'(ifa.ev_pol),   64'(0));
`ifdef RO_CAPTURE_TIMESTAMP_EN
        check("t1_ts",    64'(ifa.ev_ts),    64'(1));
`endif
        cyc(1'b0, 1'b0);
        check("t1_gone",  64'(ifa.ev_valid), 64'(0));
        check("t1_hold",  64'(ifa.ev_core),  64'(1));

        // Events in every slot: schedule order, N_CORES discard and wrap slots.
        do_reset();
        repeat (34) cyc(1'b1, 1'($urandom_range(0, 1)));
        repeat (3) cyc(1'b0, 1'b0);

        // Overflow with a stalled consumer, then continuous traffic at full level.
        do_reset();
        drv_ready = 1'b0;
        repeat (10) cyc(1'b1, 1'($urandom_range(0, 1)));
        cyc(1'b1, 1'($urandom_range(0, 1)));
        check("ovf_level", 64'(ifa.fifo_level), 64'(8));
        check("ovf_flag",  64'(ifa.overflow),   64'(1));
        check("ovf_head",  64'(ifa.ev_core),    64'(1));
        drv_ready = 1'b1;
        repeat (12) cyc(1'b1, 1'($urandom_range(0, 1)));
        check("full_level", 64'(ifa.fifo_level), 64'(8));
        repeat (12) cyc(1'b0, 1'b0);
        check("drain_valid", 64'(ifa.ev_valid), 64'(0));
        check("ovf_sticky",  64'(ifa.overflow), 64'(1));

        // Reset while three words are buffered.
        do_reset();
        drv_ready = 1'b0;
        repeat (3) cyc(1'b1, 1'($urandom_range(0, 1)));
        cyc(1'b0, 1'b0);
        check("mid_level", 64'(ifa.fifo_level), 64'(3));
        do_reset();
        drv_ready = 1'b1;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        check("post_valid", 64'(ifa.ev_valid), 64'(1));
        check("post_core",  64'(ifa.ev_core),  64'(1));
        check("post_pol",   64'(ifa.ev_pol),   64'(1));
        repeat (3) cyc(1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
